// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Handles one bit per cycle (shift-add multiply, restoring divide) with signed support.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_d, r_a, r_hi, r_lo;
  logic            r_is_div, r_neg_q, r_neg_r, r_dz, r_busy, r_done;

  logic            w_idle_free, w_accept, w_signed;
  logic [W-1:0]    w_abs_a, w_abs_b, w_addend;
  logic [W:0]      w_sum, w_rem, w_diff;
  logic [2*W-1:0]  w_mul_nxt, w_div_nxt, w_prod;
  logic [W-1:0]    w_quo, w_remf;

  // busy trails the state by one cycle, so IDLE only accepts work once busy is low
  assign w_idle_free = (r_state == S_IDLE) && !r_busy;
  assign w_accept    = w_idle_free && start;
  assign w_signed    = ~op[0];
  assign w_abs_a     = (w_signed && a[W-1]) ? (W'(0) - a) : a;
  assign w_abs_b     = (w_signed && b[W-1]) ? (W'(0) - b) : b;

  // One shift-add multiply step: accumulate into the upper half, shift right
  assign w_addend  = r_acc[0] ? r_d : W'(0);
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};

  // One restoring divide step: partial remainder in the upper half, quotient bits shift in below
  assign w_rem     = r_acc[2*W-1:W-1];
  assign w_diff    = w_rem - {1'b0, r_d};
  assign w_div_nxt = w_diff[W] ? {r_acc[2*W-2:0], 1'b0}
                               : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_prod = r_neg_q ? ((2*W)'(0) - r_acc) : r_acc;
  assign w_quo  = r_neg_q ? (W'(0) - r_acc[W-1:0]) : r_acc[W-1:0];
  assign w_remf = r_neg_r ? (W'(0) - r_acc[2*W-1:W]) : r_acc[2*W-1:W];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(0)) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_d      <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_FIXUP);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= op[1];
            r_cnt    <= CW'(31);
            r_acc    <= {W'(0), w_abs_a};
            r_d      <= w_abs_b;
            r_a      <= a;
            r_neg_q  <= w_signed && (a[W-1] ^ b[W-1]);
            r_neg_r  <= w_signed && a[W-1];
            r_dz     <= op[1] && (b == W'(0));
          end else if (w_idle_free) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          if (r_cnt != CW'(0)) r_cnt <= r_cnt - CW'(1);
        end
        S_FIXUP: begin
          if (!r_is_div) begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end else if (r_dz) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_remf;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend (rs); sampled only with an accepted start.
REQ-007 b  input  32  multiplier or divisor (rt); sampled only with an accepted start.
REQ-008 mthi, mtlo  input  1 each  direct writes of wdata into HI or LO.
REQ-009 wdata  input  32  data for mthi/mtlo.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse when HI/LO take a result.
REQ-012 hi, lo  output  32 each  architectural HI and LO registers, driven from flops.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIXUP.
REQ-014 IDLE: start=1 SHALL be accepted, latch a, b and op, load iteration count 31, and move to RUN.
REQ-015 Signed ops SHALL operate on absolute values and record the result signs: product sign a[31]^b[31], quotient sign a[31]^b[31], remainder sign a[31].
REQ-016 RUN SHALL process one bit per cycle for exactly 32 cycles (shift-add multiply, restoring divide), then move to FIXUP.
REQ-017 FIXUP SHALL apply two's-complement sign correction, write HI/LO, assert done for that cycle, and return to IDLE.
REQ-018 Latency: start accepted at edge N; busy=1 after edges N+1..N+33; HI/LO updated and done=1 after edge N+33; busy=0 and done=0 after edge N+34.
REQ-019 Multiply results SHALL be HI = product[63:32] and LO = product[31:0]; MULT is a signed 64-bit product and MULTU an unsigned one.
REQ-020 Divide results SHALL be LO = quotient (truncated toward zero) and HI = remainder (same sign as dividend or zero).
REQ-021 Divide by zero (b=0), DIV or DIVU: SHALL complete with normal latency, with HI=a and LO=32'hFFFFFFFF.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0, with no trap.
REQ-023 start asserted while busy=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-024 mthi/mtlo asserted in IDLE with start=0 SHALL load wdata into HI/LO at that edge; both asserted SHALL write both registers.
REQ-025 start and mthi/mtlo asserted together in IDLE: start SHALL win and the writes SHALL be ignored.
REQ-026 mthi/mtlo asserted while busy=1 SHALL be ignored.
REQ-027 hi and lo SHALL hold their values between writes; they are not disturbed during RUN.

Reset
REQ-028 While reset=1: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0, and internal operand/accumulator registers cleared.
REQ-029 Reset asserted mid-RUN or mid-FIXUP SHALL abort the operation immediately; after release no done pulse occurs and HI/LO read 0.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-031 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 34 cycles HI=32'hFFFFFFFE, LO=32'h00000001, done pulses once.
REQ-032 MULT a=-3 (32'hFFFFFFFD), b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-033 DIVU a=100, b=0 -> HI=100, LO=32'hFFFFFFFF; DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-034 DIVU 100/7 with a second start (MULTU 2*2) at cycle 10 -> second start ignored; result HI=2, LO=14; busy falls exactly 34 cycles after first start.
REQ-035 mthi with wdata=32'h12345678 in IDLE -> HI=32'h12345678 next cycle; mtlo during RUN -> LO unchanged; start+mtlo same cycle -> only the op result lands in LO.
REQ-036 reset pulsed at RUN cycle 15 -> busy=0 and hi=lo=0 immediately; no done pulse; a new MULTU 3*5 after release gives LO=15, HI=0.
